// File: rtl/trigger_delay_pkg.sv
// Shared definitions for the trigger delay sequencer.
// Provides the 2-bit edge-type codes driven to the CDC edge detector and
// the sequencer state enumeration.
package trigger_delay_pkg;

  localparam logic [1:0] EDGE_NONE    = 2'b00;
  localparam logic [1:0] EDGE_RISING  = 2'b01;
  localparam logic [1:0] EDGE_FALLING = 2'b10;
  localparam logic [1:0] EDGE_BOTH    = 2'b11;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StDelay = 3'd2,
    StPulse = 3'd3,
    StDone  = 3'd4
  } td_state_t;

endpackage

// File: rtl/td_down_counter.sv
// Loadable down-counter with zero flag. Load has priority over enable and
// the count holds at zero instead of wrapping.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_load          load i_load_val on the next edge
//   i_load_val      value to load
//   i_en            decrement by one (ignored at zero)
//   o_zero          count == 0
module td_down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/trigger_delay_sequencer.sv
// Trigger delay sequencer: configures one edge-detector channel, counts N
// qualifying edge pulses, waits a programmed delay and then drives a trigger
// pulse of programmed width.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_arm / i_disarm   1-cycle strobes; disarm wins over everything
//   i_cfg_*            configuration, latched into shadow regs on arm
//   i_edge_pulse       synchronous pulse from the edge detector
//   o_det_edge_type    edge type driven to the detector
//   o_trig_out         registered trigger output
//   o_armed/o_busy/o_done  state decodes (ARMED, DELAY|PULSE, DONE)
//   o_missed_edges     saturating count of edges seen in DELAY/PULSE
module trigger_delay_sequencer
  import trigger_delay_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DELAY_W = 32,
  parameter int unsigned WIDTH_W = 16,
  parameter int unsigned MISS_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_arm,
  input  logic               i_disarm,
  input  logic [1:0]         i_cfg_edge_type,
  input  logic [CNT_W-1:0]   i_cfg_edge_count,
  input  logic [DELAY_W-1:0] i_cfg_delay,
  input  logic [WIDTH_W-1:0] i_cfg_width,
  input  logic               i_cfg_one_shot,
  input  logic               i_edge_pulse,
  output logic [1:0]         o_det_edge_type,
  output logic               o_trig_out,
  output logic               o_armed,
  output logic               o_busy,
  output logic               o_done,
  output logic [MISS_W-1:0]  o_missed_edges
);

  td_state_t r_state, w_state_nxt;

  // Shadow configuration
  logic [1:0]         r_edge_type;
  logic [CNT_W-1:0]   r_cnt_cfg;
  logic [DELAY_W-1:0] r_delay_cfg;
  logic [WIDTH_W-1:0] r_width_cfg;
  logic               r_one_shot;

  logic [CNT_W-1:0]   r_edge_cnt;
  logic [MISS_W-1:0]  r_missed;
  logic               r_trig_out;

  logic               w_arm_ok;
  logic               w_busy;
  logic               w_dly_load, w_dly_en, w_dly_zero;
  logic               w_wid_load, w_wid_en, w_wid_zero;
  logic [DELAY_W-1:0] w_dly_load_val;
  logic [WIDTH_W-1:0] w_wid_load_val;
  logic [CNT_W-1:0]   w_cnt_reload;

  assign w_arm_ok = i_arm && !i_disarm && ((r_state == StIdle) || (r_state == StDone));
  assign w_busy   = (r_state == StDelay) || (r_state == StPulse);

  // Counters hold value-1; a zero configuration behaves like one.
  assign w_dly_load_val = r_delay_cfg - DELAY_W'(1);
  assign w_wid_load_val = (r_width_cfg == '0) ? '0 : r_width_cfg - WIDTH_W'(1);
  assign w_cnt_reload   = (r_cnt_cfg == '0) ? '0 : r_cnt_cfg - CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_dly_load  = 1'b0;
    w_dly_en    = 1'b0;
    w_wid_load  = 1'b0;
    w_wid_en    = 1'b0;
    if (i_disarm) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_arm) w_state_nxt = StArmed;
        end
        StArmed: begin
          if (i_edge_pulse && (r_edge_cnt == '0)) begin
            if (r_delay_cfg == '0) begin
              w_state_nxt = StPulse;
              w_wid_load  = 1'b1;
            end else begin
              w_state_nxt = StDelay;
              w_dly_load  = 1'b1;
            end
          end
        end
        StDelay: begin
          if (w_dly_zero) begin
            w_state_nxt = StPulse;
            w_wid_load  = 1'b1;
          end else begin
            w_dly_en = 1'b1;
          end
        end
        StPulse: begin
          if (w_wid_zero) begin
            w_state_nxt = r_one_shot ? StDone : StArmed;
          end else begin
            w_wid_en = 1'b1;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_trig_out  <= 1'b0;
      r_edge_type <= EDGE_NONE;
      r_cnt_cfg   <= '0;
      r_delay_cfg <= '0;
      r_width_cfg <= '0;
      r_one_shot  <= 1'b0;
      r_edge_cnt  <= '0;
      r_missed    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      // Registered copy of "in PULSE" so the pin is glitch-free.
      r_trig_out <= (w_state_nxt == StPulse);

      if (w_arm_ok) begin
        r_edge_type <= i_cfg_edge_type;
        r_cnt_cfg   <= i_cfg_edge_count;
        r_delay_cfg <= i_cfg_delay;
        r_width_cfg <= i_cfg_width;
        r_one_shot  <= i_cfg_one_shot;
        r_edge_cnt  <= (i_cfg_edge_count == '0) ? '0 : i_cfg_edge_count - CNT_W'(1);
      end else if (!i_disarm && (r_state == StPulse) && (w_state_nxt == StArmed)) begin
        r_edge_cnt <= w_cnt_reload;
      end else if (!i_disarm && (r_state == StArmed) && i_edge_pulse &&
                   (r_edge_cnt != '0)) begin
        r_edge_cnt <= r_edge_cnt - CNT_W'(1);
      end

      if (w_arm_ok) begin
        r_missed <= '0;
      end else if (w_busy && i_edge_pulse && (r_missed != '1)) begin
        r_missed <= r_missed + MISS_W'(1);
      end
    end
  end

  td_down_counter #(
    .W(DELAY_W)
  ) u_delay_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_dly_load),
    .i_load_val (w_dly_load_val),
    .i_en       (w_dly_en),
    .o_zero     (w_dly_zero)
  );

  td_down_counter #(
    .W(WIDTH_W)
  ) u_width_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_wid_load),
    .i_load_val (w_wid_load_val),
    .i_en       (w_wid_en),
    .o_zero     (w_wid_zero)
  );

  assign o_trig_out      = r_trig_out;
  assign o_armed         = (r_state == StArmed);
  assign o_busy          = w_busy;
  assign o_done          = (r_state == StDone);
  assign o_det_edge_type = ((r_state == StArmed) || w_busy) ? r_edge_type : EDGE_NONE;
  assign o_missed_edges  = r_missed;

endmodule

// File: tb/tb_trigger_delay_sequencer.sv
// Directed bench for trigger_delay_sequencer. Inputs change 1 ns after a
// rising edge; outputs are sampled at the same point, so "cycle n" below is
// the value visible after n rising edges counted from the reference cycle.
module tb_trigger_delay_sequencer;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DELAY_W = 32;
  localparam int unsigned WIDTH_W = 16;
  localparam int unsigned MISS_W  = 8;

  logic               clk;
  logic               rst_n;
  logic               arm;
  logic               disarm;
  logic [1:0]         cfg_edge_type;
  logic [CNT_W-1:0]   cfg_edge_count;
  logic [DELAY_W-1:0] cfg_delay;
  logic [WIDTH_W-1:0] cfg_width;
  logic               cfg_one_shot;
  logic               edge_pulse;
  logic [1:0]         det_edge_type;
  logic               trig_out;
  logic               armed;
  logic               busy;
  logic               done;
  logic [MISS_W-1:0]  missed_edges;

  int num_checks = 0;
  int num_errors = 0;

  trigger_delay_sequencer #(
    .CNT_W   (CNT_W),
    .DELAY_W (DELAY_W),
    .WIDTH_W (WIDTH_W),
    .MISS_W  (MISS_W)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_arm            (arm),
    .i_disarm         (disarm),
    .i_cfg_edge_type  (cfg_edge_type),
    .i_cfg_edge_count (cfg_edge_count),
    .i_cfg_delay      (cfg_delay),
    .i_cfg_width      (cfg_width),
    .i_cfg_one_shot   (cfg_one_shot),
    .i_edge_pulse     (edge_pulse),
    .o_det_edge_type  (det_edge_type),
    .o_trig_out       (trig_out),
    .o_armed          (armed),
    .o_busy           (busy),
    .o_done           (done),
    .o_missed_edges   (missed_edges)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] et, input int cnt, input int dly, input int wid,
                         input logic os);
    cfg_edge_type  = et;
    cfg_edge_count = CNT_W'(cnt);
    cfg_delay      = DELAY_W'(dly);
    cfg_width      = WIDTH_W'(wid);
    cfg_one_shot   = os;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    arm        = 1'b0;
    disarm     = 1'b0;
    edge_pulse = 1'b0;
    set_cfg(2'b01, 1, 0, 1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_trig", 32'(trig_out), 0);
    check_eq("rst_armed", 32'(armed), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_missed", 32'(missed_edges), 0);
    check_eq("rst_edge_type", 32'(det_edge_type), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Test 1: count=1, delay=0, width=1
    set_cfg(2'b01, 1, 0, 1, 1'b1);
    do_arm();
    check_eq("t1_armed", 32'(armed), 1);
    check_eq("t1_edge_type", 32'(det_edge_type), 1);
    for (int c = 0; c < 3; c++) begin
      edge_pulse = (c == 0);
      tick();
      check_eq("t1_trig", 32'(trig_out), 32'(c + 1 == 1));
    end
    edge_pulse = 1'b0;
    check_eq("t1_done", 32'(done), 1);
    check_eq("t1_done_edge_type", 32'(det_edge_type), 0);

    // Test 2: count=3, delay=10, width=4; cfg changes after arm must be ignored
    set_cfg(2'b10, 3, 10, 4, 1'b1);
    do_arm();
    set_cfg(2'b11, 1, 0, 1, 1'b0);
    check_eq("t2_edge_type", 32'(det_edge_type), 2);
    for (int c = 0; c < 28; c++) begin
      edge_pulse = (c == 0) || (c == 5) || (c == 9);
      tick();
      check_eq("t2_trig", 32'(trig_out), 32'((c + 1 >= 20) && (c + 1 <= 23)));
      check_eq("t2_busy", 32'(busy), 32'((c + 1 >= 10) && (c + 1 <= 23)));
      check_eq("t2_done", 32'(done), 32'(c + 1 >= 24));
    end
    edge_pulse = 1'b0;

    // Test 3: auto re-arm, count=1, delay=2, width=2, edges 20 apart
    set_cfg(2'b01, 1, 2, 2, 1'b0);
    do_arm();
    for (int c = 0; c < 30; c++) begin
      edge_pulse = (c == 0) || (c == 20);
      tick();
      check_eq("t3_trig", 32'(trig_out),
               32'((c + 1 == 3) || (c + 1 == 4) || (c + 1 == 23) || (c + 1 == 24)));
      check_eq("t3_armed", 32'(armed),
               32'(((c + 1 >= 5) && (c + 1 <= 20)) || (c + 1 >= 25)));
    end
    edge_pulse = 1'b0;
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    check_eq("t3_disarm_idle", 32'(armed), 0);

    // Test 4: 300 edges while delaying; missed count saturates at 255
    set_cfg(2'b01, 1, 350, 3, 1'b1);
    do_arm();
    for (int c = 0; c < 356; c++) begin
      edge_pulse = (c <= 300);
      tick();
      if (c + 1 == 255) check_eq("t4_missed_254", 32'(missed_edges), 254);
      if (c + 1 == 301) check_eq("t4_missed_sat", 32'(missed_edges), 255);
      if (c + 1 >= 349)
        check_eq("t4_trig", 32'(trig_out), 32'((c + 1 >= 351) && (c + 1 <= 353)));
    end
    edge_pulse = 1'b0;
    check_eq("t4_missed_end", 32'(missed_edges), 255);
    check_eq("t4_done", 32'(done), 1);

    // Test 5: disarm in 2nd PULSE cycle of width=8
    set_cfg(2'b11, 1, 0, 8, 1'b1);
    do_arm();
    check_eq("t5_missed_clr", 32'(missed_edges), 0);
    for (int c = 0; c < 3; c++) begin
      edge_pulse = (c <= 1);
      disarm     = (c == 2);
      tick();
      if (c + 1 <= 2) check_eq("t5_trig_hi", 32'(trig_out), 1);
    end
    edge_pulse = 1'b0;
    disarm     = 1'b0;
    check_eq("t5_trig_lo", 32'(trig_out), 0);
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_armed", 32'(armed), 0);
    check_eq("t5_done", 32'(done), 0);
    check_eq("t5_edge_type", 32'(det_edge_type), 0);
    check_eq("t5_missed_kept", 32'(missed_edges), 1);
    // Disarm beats a simultaneous arm.
    arm    = 1'b1;
    disarm = 1'b1;
    tick();
    arm    = 1'b0;
    disarm = 1'b0;
    check_eq("t5_arm_disarm", 32'(armed), 0);
    check_eq("t5_missed_kept2", 32'(missed_edges), 1);

    // Test 6: asynchronous reset mid-DELAY
    set_cfg(2'b01, 1, 20, 2, 1'b1);
    do_arm();
    for (int c = 0; c < 5; c++) begin
      edge_pulse = (c <= 3);
      tick();
    end
    edge_pulse = 1'b0;
    check_eq("t6_busy_pre", 32'(busy), 1);
    check_eq("t6_missed_pre", 32'(missed_edges), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", 32'(busy), 0);
    check_eq("t6_rst_trig", 32'(trig_out), 0);
    check_eq("t6_rst_missed", 32'(missed_edges), 0);
    check_eq("t6_rst_edge_type", 32'(det_edge_type), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_cfg(2'b10, 1, 0, 1, 1'b1);
    do_arm();
    check_eq("t6_rearm", 32'(armed), 1);
    edge_pulse = 1'b1;
    tick();
    edge_pulse = 1'b0;
    check_eq("t6_trig", 32'(trig_out), 1);
    tick();
    check_eq("t6_trig_end", 32'(trig_out), 0);
    check_eq("t6_done", 32'(done), 1);

    // Async drop of trig_out while pulsing
    set_cfg(2'b01, 1, 0, 4, 1'b1);
    do_arm();
    edge_pulse = 1'b1;
    tick();
    edge_pulse = 1'b0;
    check_eq("t6b_trig_hi", 32'(trig_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6b_trig_async", 32'(trig_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
